multiplier_2c_seq: RTL and testbench

MULTIPLIER_2C_SEQ -- requirements
Module: multiplier_2c_seq

---
 rtl/multiplier_2c_seq.sv | 109 ++++++++++
 tb/tb_multiplier_2c_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_2c_seq.sv
// Sequential signed x signed multiplier: one partial product per clock, MSB row subtracted,
// with a scaled (arithmetic right shift by FRAC) result and optional saturation.
module multiplier_2c_seq #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned FRAC  = 2,
  parameter int unsigned SAT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   m_out,
  output logic [2*WIDTH-1:0] p_full,
  output logic               ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CW-1:0]   cnt_q;

  logic            accept_c, last_c, ovf_c;
  logic [PW-1:0]   pp_c, acc_d, top_c;
  logic [WIDTH-1:0] m_c;

  assign accept_c  = in_valid && in_ready;
  assign last_c    = (cnt_q == CW'(WIDTH - 1));
  assign out_valid = (state_q == DONE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and ready; DONE passes out_ready through so a retire can accept on the same edge
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: if (last_c) state_d = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) in_ready = 1'b0;
  end

  // Partial product for the current multiplier bit; the sign row is subtracted
  always_comb begin
    pp_c  = mplr_q[0] ? mcand_q : '0;
    acc_d = last_c ? (acc_q - pp_c) : (acc_q + pp_c);
  end

  // Scaling, overflow detection and optional clamp of the final product
  always_comb begin
    top_c = $signed(acc_d) >>> (FRAC + WIDTH - 1);
    ovf_c = !((top_c == '0) || (&top_c));
    m_c   = acc_d[FRAC +: WIDTH];
    if ((SAT != 0) && ovf_c)
      m_c = acc_d[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Datapath: operand capture, iteration, and result registers held through DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p_full  <= '0;
      m_out   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (accept_c) begin
        acc_q   <= '0;
        mcand_q <= {{WIDTH{x[WIDTH-1]}}, x};
        mplr_q  <= y;
        cnt_q   <= '0;
      end else if (state_q == BUSY) begin
        acc_q   <= acc_d;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
      end
      if ((state_q == BUSY) && last_c) begin
        p_full <= acc_d;
        m_out  <= m_c;
        ovf    <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_2c_seq.sv
// Bench for multiplier_2c_seq: directed vector table, back-pressure and reset-abort sequences,
// and sweeps over several widths and every FRAC against a behavioural reference.
module tb_multiplier_2c_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Directed pair: same operands, wrap and saturate variants
  logic       iv = 1'b0, ordy = 1'b1;
  logic [3:0] xa = '0, ya = '0;
  logic       irdy0, ov0, ovf0, irdy1, ov1, ovf1;
  logic [3:0] m0, m1;
  logic [7:0] p0, p1;

  multiplier_2c_seq #(.WIDTH(4), .FRAC(2), .SAT(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(irdy0), .x(xa), .y(ya),
    .out_valid(ov0), .out_ready(ordy), .m_out(m0), .p_full(p0), .ovf(ovf0));
  multiplier_2c_seq #(.WIDTH(4), .FRAC(2), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(irdy1), .x(xa), .y(ya),
    .out_valid(ov1), .out_ready(ordy), .m_out(m1), .p_full(p1), .ovf(ovf1));

  // Sweep groups; SAT alternates with the instance index
  logic        iv4 = 1'b0, iv8 = 1'b0, iv16 = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic [15:0] x16 = '0, y16 = '0;
  logic [3:0]  m4[5];  logic [7:0]  p4[5];  logic ov4[5], rd4[5], of4[5];
  logic [7:0]  m8[9];  logic [15:0] p8[9];  logic ov8[9], rd8[9], of8[9];
  logic [15:0] m16[4]; logic [31:0] p16[4]; logic ov16[4], rd16[4], of16[4];

  for (genvar g = 0; g < 5; g++) begin : g_w4
    multiplier_2c_seq #(.WIDTH(4), .FRAC(g), .SAT(g % 2)) u (
      .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rd4[g]), .x(x4), .y(y4),
      .out_valid(ov4[g]), .out_ready(1'b1), .m_out(m4[g]), .p_full(p4[g]), .ovf(of4[g]));
  end
  for (genvar g = 0; g < 9; g++) begin : g_w8
    multiplier_2c_seq #(.WIDTH(8), .FRAC(g), .SAT(g % 2)) u (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rd8[g]), .x(x8), .y(y8),
      .out_valid(ov8[g]), .out_ready(1'b1), .m_out(m8[g]), .p_full(p8[g]), .ovf(of8[g]));
  end
  for (genvar g = 0; g < 4; g++) begin : g_w16
    multiplier_2c_seq #(.WIDTH(16), .FRAC((g == 3) ? 16 : g * 5), .SAT(g % 2)) u (
      .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(rd16[g]), .x(x16), .y(y16),
      .out_valid(ov16[g]), .out_ready(1'b1), .m_out(m16[g]), .p_full(p16[g]), .ovf(of16[g]));
  end

  typedef struct {
    logic [3:0] x, y;
    logic [7:0] p;
    logic [3:0] mw, ms;
    logic       o;
  } vec_t;
  vec_t tbl[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: exact product, floor shift, range check, clamp
  function automatic void mdl(input longint xs, input longint ys, input int w, input int f,
                              input int s, output longint pe, output longint me, output bit oe);
    longint q, lo, hi;
    pe = xs * ys;
    q  = pe >>> f;
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    oe = (q < lo) || (q > hi);
    me = q;
    if (s != 0 && oe) me = (pe < 0) ? lo : hi;
  endfunction

  function automatic longint sx(input int w, input longint r);
    longint v;
    v = r & ((longint'(1) << w) - 1);
    if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic grp_ov(input int w);
    case (w)
      4:       return ov4[0];
      8:       return ov8[0];
      default: return ov16[0];
    endcase
  endfunction

  task automatic acc_main(input logic [3:0] xv, input logic [3:0] yv, output int lat);
    int n;
    n = 0;
    while (!irdy0 && n < 20) begin step(); n++; end
    xa = xv; ya = yv; iv = 1'b1;
    step();
    iv = 1'b0; xa = 4'($urandom); ya = 4'($urandom);
    lat = 0;
    while (!ov0 && lat < 20) begin step(); lat++; end
  endtask

  task automatic go_grp(input int w, input longint xs, input longint ys, output int lat);
    case (w)
      4:       begin x4  = 4'(xs);  y4  = 4'(ys);  iv4  = 1'b1; end
      8:       begin x8  = 8'(xs);  y8  = 8'(ys);  iv8  = 1'b1; end
      default: begin x16 = 16'(xs); y16 = 16'(ys); iv16 = 1'b1; end
    endcase
    step();
    iv4 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
    x4 = 4'($urandom); x8 = 8'($urandom); x16 = 16'($urandom);
    lat = 0;
    while (!grp_ov(w) && lat < 40) begin step(); lat++; end
  endtask

  task automatic chk_grp(input int w, input longint xs, input longint ys);
    longint pe, me, pm, mm;
    bit oe;
    int nf;
    nf = (w == 4) ? 5 : ((w == 8) ? 9 : 4);
    pm = (longint'(1) << (2 * w)) - 1;
    mm = (longint'(1) << w) - 1;
    for (int k = 0; k < nf; k++) begin
      int f;
      logic [63:0] ap, am;
      logic ao, av, ar;
      f = (w == 16) ? ((k == 3) ? 16 : k * 5) : k;
      case (w)
        4:       begin ap = 64'(p4[k]);  am = 64'(m4[k]);  ao = of4[k];  av = ov4[k];  ar = rd4[k];  end
        8:       begin ap = 64'(p8[k]);  am = 64'(m8[k]);  ao = of8[k];  av = ov8[k];  ar = rd8[k];  end
        default: begin ap = 64'(p16[k]); am = 64'(m16[k]); ao = of16[k]; av = ov16[k]; ar = rd16[k]; end
      endcase
      mdl(xs, ys, w, f, k % 2, pe, me, oe);
      chk($sformatf("w%0d_f%0d_p x=%0d y=%0d", w, f, xs, ys), ap, 64'(pe & pm));
      chk($sformatf("w%0d_f%0d_m x=%0d y=%0d", w, f, xs, ys), am, 64'(me & mm));
      chk($sformatf("w%0d_f%0d_ovf x=%0d y=%0d", w, f, xs, ys), 64'(ao), 64'(oe));
      chk($sformatf("w%0d_f%0d_vld_rdy", w, f), 64'({av, ar}), 64'(2'b11));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;
    tbl[0] = '{4'h3, 4'h2, 8'h06, 4'h1, 4'h1, 1'b0};
    tbl[1] = '{4'hF, 4'h1, 8'hFF, 4'hF, 4'hF, 1'b0};
    tbl[2] = '{4'h8, 4'h8, 8'h40, 4'h0, 4'h7, 1'b1};
    tbl[3] = '{4'h7, 4'h8, 8'hC8, 4'h2, 4'h8, 1'b1};
    tbl[4] = '{4'h7, 4'h7, 8'h31, 4'hC, 4'h7, 1'b1};
    tbl[5] = '{4'h9, 4'h6, 8'hD6, 4'h5, 4'h8, 1'b1};
    tbl[6] = '{4'h5, 4'hD, 8'hF1, 4'hC, 4'hC, 1'b0};
    tbl[7] = '{4'h0, 4'hB, 8'h00, 4'h0, 4'h0, 1'b0};

    // Reset state
    #2;
    chk("rst_out_valid", 64'(ov0), 64'(0));
    chk("rst_in_ready", 64'(irdy0), 64'(0));
    chk("rst_outputs", 64'({p0, m0, ovf0}), 64'(0));
    step(); step();
    reset = 1'b0;
    #1;
    chk("rdy_after_reset", 64'(irdy0), 64'(1));

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      acc_main(tbl[i].x, tbl[i].y, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(4));
      chk($sformatf("v%0d_p", i), 64'(p0), 64'(tbl[i].p));
      chk($sformatf("v%0d_m_wrap", i), 64'(m0), 64'(tbl[i].mw));
      chk($sformatf("v%0d_ovf", i), 64'(ovf0), 64'(tbl[i].o));
      chk($sformatf("v%0d_p_sat", i), 64'(p1), 64'(tbl[i].p));
      chk($sformatf("v%0d_m_sat", i), 64'(m1), 64'(tbl[i].ms));
      chk($sformatf("v%0d_ovf_sat", i), 64'(ovf1), 64'(tbl[i].o));
    end

    // Back-pressure with same-edge retire and accept
    step(); step();
    ordy = 1'b0;
    acc_main(4'h3, 4'h2, lat);
    chk("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d", i), 64'({ov0, irdy0, p0, m0, ovf0}), 64'({1'b1, 1'b0, 8'h06, 4'h1, 1'b0}));
    end
    xa = 4'hF; ya = 4'h1; iv = 1'b1; ordy = 1'b1;
    #1;
    chk("bp_ready_passthru", 64'(irdy0), 64'(1));
    step();
    iv = 1'b0; xa = 4'h7; ya = 4'h7;
    chk("bp_retired", 64'(ov0), 64'(0));
    lat = 0;
    while (!ov0 && lat < 20) begin step(); lat++; end
    chk("bp_next_latency", 64'(lat), 64'(4));
    chk("bp_next_p", 64'(p0), 64'(8'hFF));
    chk("bp_next_m", 64'(m0), 64'(4'hF));

    // Reset in the middle of an operation
    step();
    xa = 4'h7; ya = 4'h7; iv = 1'b1;
    step();
    iv = 1'b0;
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("abort_out_valid", 64'(ov0), 64'(0));
    chk("abort_in_ready", 64'(irdy0), 64'(0));
    chk("abort_outputs", 64'({p0, m0, ovf0}), 64'(0));
    step(); step();
    reset = 1'b0;
    #1;
    chk("abort_rdy_release", 64'(irdy0), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov0) seen = 1'b1;
    end
    chk("abort_no_pulse", 64'(seen), 64'(0));

    // Exhaustive 4-bit, random 8- and 16-bit, every instance checked
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        go_grp(4, longint'(a), longint'(b), lat);
        chk("w4_latency", 64'(lat), 64'(4));
        chk_grp(4, longint'(a), longint'(b));
      end
    end
    for (int i = 0; i < 2500; i++) begin
      longint xs, ys;
      xs = sx(8, longint'($urandom));
      ys = sx(8, longint'($urandom));
      if (i == 0) begin xs = -128; ys = -128; end
      go_grp(8, xs, ys, lat);
      chk("w8_latency", 64'(lat), 64'(8));
      chk_grp(8, xs, ys);
    end
    for (int i = 0; i < 1500; i++) begin
      longint xs, ys;
      xs = sx(16, longint'($urandom));
      ys = sx(16, longint'($urandom));
      if (i == 0) begin xs = -32768; ys = -32768; end
      if (i == 1) begin xs = 32767; ys = -32768; end
      go_grp(16, xs, ys, lat);
      chk("w16_latency", 64'(lat), 64'(16));
      chk_grp(16, xs, ys);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
